// File: rtl/cam_pkg.sv
// cam_pkg: shared FSM states, default geometry and RGB444 packing for the camera capture path
package cam_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} cam_state_e;
  localparam int H_OUT_DEF = 320;
  localparam int V_OUT_DEF = 240;
  localparam int DEPTH_DEF = 76800;
  localparam int ADR_W_DEF = 19;
  localparam int CNT_W = 16;
  localparam int R_HI = 11, R_LO = 8, G_HI = 7, G_LO = 4, B_HI = 3, B_LO = 0;
  function automatic logic [11:0] rgb444(input logic [3:0] r, input logic [7:0] gb);
    logic [11:0] p;
    p[R_HI:R_LO] = r;
    p[G_HI:G_LO] = gb[7:4];
    p[B_HI:B_LO] = gb[3:0];
    return p;
  endfunction
endpackage

// File: rtl/cam_sync.sv
// cam_sync: 2-flop synchronizers for the camera pins plus registered pclk tick and href/vsync edge pulses
//   in : clk_i, rst_n, cam_pclk_i, cam_href_i, cam_vsync_i, cam_data_i[7:0]
//   out: tick_o (pclk rising), href_o/data_o (sampled on tick), href_fall_o, vs_rise_o, vs_fall_o
module cam_sync (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       cam_pclk_i,
  input  logic       cam_href_i,
  input  logic       cam_vsync_i,
  input  logic [7:0] cam_data_i,
  output logic       tick_o,
  output logic       href_o,
  output logic [7:0] data_o,
  output logic       href_fall_o,
  output logic       vs_rise_o,
  output logic       vs_fall_o
);
  logic [2:0] pclk_q, href_q, vs_q;
  logic [7:0] data1_q, data2_q, data_d;
  logic       tick_d, href_d, hfall_d, vrise_d, vfall_d;
  always_comb begin
    tick_d  = pclk_q[1] & ~pclk_q[2];
    href_d  = tick_d ? href_q[1] : href_o;
    data_d  = tick_d ? data2_q : data_o;
    hfall_d = ~href_q[1] & href_q[2];
    vrise_d = vs_q[1] & ~vs_q[2];
    vfall_d = ~vs_q[1] & vs_q[2];
  end
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pclk_q      <= '0;
      href_q      <= '0;
      vs_q        <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      tick_o      <= 1'b0;
      href_o      <= 1'b0;
      data_o      <= '0;
      href_fall_o <= 1'b0;
      vs_rise_o   <= 1'b0;
      vs_fall_o   <= 1'b0;
    end else begin
      pclk_q      <= {pclk_q[1:0], cam_pclk_i};
      href_q      <= {href_q[1:0], cam_href_i};
      vs_q        <= {vs_q[1:0], cam_vsync_i};
      data1_q     <= cam_data_i;
      data2_q     <= data1_q;
      tick_o      <= tick_d;
      href_o      <= href_d;
      data_o      <= data_d;
      href_fall_o <= hfall_d;
      vs_rise_o   <= vrise_d;
      vs_fall_o   <= vfall_d;
    end
  end
endmodule

// File: rtl/cam_capture.sv
// cam_capture: OV7670 byte stream to RGB444 pixels, writes one armed frame into the frame-buffer RAM
//   in : clk_i, rst_n (async, active low), start_i, cam_pclk_i, cam_href_i, cam_vsync_i, cam_data_i[7:0]
//   out: we_o, adr_o[ADR_W-1:0], dat_o[11:0], busy_o, done_o, err_o
//   CAM_CAPTURE_DECIM_EN: 2x2 decimation of a 640x480 sensor stream
module cam_capture import cam_pkg::*; #(
  parameter int H_OUT = H_OUT_DEF,
  parameter int V_OUT = V_OUT_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADR_W = ADR_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             cam_pclk_i,
  input  logic             cam_href_i,
  input  logic             cam_vsync_i,
  input  logic [7:0]       cam_data_i,
  output logic             we_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [11:0]      dat_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);
  localparam logic [CNT_W-1:0] H_LIM = CNT_W'(H_OUT);
  localparam logic [CNT_W-1:0] V_LIM = CNT_W'(V_OUT);
  localparam logic [ADR_W-1:0] LAST  = ADR_W'(DEPTH - 1);
  logic             tick, href, href_fall, vs_rise, vs_fall, vs_rise_q;
  logic [7:0]       data;
  cam_state_e       state_q, state_d;
  logic             phase_q, phase_d, pix_v, keep, last_wr, arm;
  logic             we_d, busy_d, done_d, err_d;
  logic [3:0]       r_q, r_d;
  logic [CNT_W-1:0] col_q, col_d, line_q, line_d;
  logic [ADR_W-1:0] adr_d;
  logic [11:0]      dat_d;
  cam_sync u_sync (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .cam_pclk_i  (cam_pclk_i),
    .cam_href_i  (cam_href_i),
    .cam_vsync_i (cam_vsync_i),
    .cam_data_i  (cam_data_i),
    .tick_o      (tick),
    .href_o      (href),
    .data_o      (data),
    .href_fall_o (href_fall),
    .vs_rise_o   (vs_rise),
    .vs_fall_o   (vs_fall)
  );
`ifdef CAM_CAPTURE_DECIM_EN
  assign keep = ~col_q[0] & ~line_q[0] & ((col_q >> 1) < H_LIM) & ((line_q >> 1) < V_LIM);
`else
  assign keep = (col_q < H_LIM) & (line_q < V_LIM);
`endif
  always_comb begin
    pix_v   = tick & href & phase_q;
    phase_d = !href ? 1'b0 : tick ? ~phase_q : phase_q;
    r_d     = (tick & href & ~phase_q) ? data[3:0] : r_q;
    col_d   = href_fall ? '0 : pix_v ? col_q + CNT_W'(1) : col_q;
    line_d  = (href_fall && col_q != '0) ? line_q + CNT_W'(1) : line_q;
    last_wr = we_o & (adr_o == LAST);
    adr_d   = (we_o && !last_wr) ? adr_o + ADR_W'(1) : adr_o;
    arm     = start_i & (state_q == IDLE || state_q == DONE);
    state_d = state_q;
    done_d  = done_o;
    err_d   = err_o;
    if (arm) begin
      state_d = WAIT_VS;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else if (state_q == WAIT_VS && vs_fall) begin
      state_d = CAPTURE;
      col_d   = '0;
      line_d  = '0;
      adr_d   = '0;
    end else if (state_q == CAPTURE && last_wr) begin
      state_d = DONE;
      done_d  = 1'b1;
    end else if (state_q == CAPTURE && vs_rise_q) begin
      // vs_rise_q lags the tick by one cycle so a write from the same tick lands before err
      state_d = DONE;
      err_d   = 1'b1;
    end
    we_d   = (state_q == CAPTURE) & pix_v & keep;
    dat_d  = pix_v ? rgb444(r_q, data) : dat_o;
    busy_d = (state_d == WAIT_VS) || (state_d == CAPTURE);
  end
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      r_q       <= '0;
      col_q     <= '0;
      line_q    <= '0;
      vs_rise_q <= 1'b0;
      we_o      <= 1'b0;
      adr_o     <= '0;
      dat_o     <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      r_q       <= r_d;
      col_q     <= col_d;
      line_q    <= line_d;
      vs_rise_q <= vs_rise;
      we_o      <= we_d;
      adr_o     <= adr_d;
      dat_o     <= dat_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
      err_o     <= err_d;
    end
  end
endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: randomized camera stream vs frame-level reference model with write scoreboard
module tb_cam_capture;
  localparam int H = 16, V = 8, DEPTH = H * V, AW = 8;
`ifdef CAM_CAPTURE_DECIM_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  typedef struct packed {logic [AW-1:0] adr; logic [11:0] dat;} wr_t;
  logic clk = 0, rst_n = 0, start_i = 0, cam_pclk = 0, cam_href = 0, cam_vsync = 0;
  logic [7:0] cam_data = 0;
  logic we_o, busy_o, done_o, err_o;
  logic [AW-1:0] adr_o;
  logic [11:0] dat_o;
  wr_t exp_q[$];
  int checks = 0, errors = 0, n_wr = 0, m_addr = 0, base = 0, rst_wr = 0;
  logic [AW-1:0] last_adr = '0;
  bit pending = 0, capturing = 0, m_done = 0, m_err = 0;

  always #5 clk = ~clk;

  cam_capture #(.H_OUT(H), .V_OUT(V), .DEPTH(DEPTH), .ADR_W(AW)) dut (
    .clk_i(clk), .rst_n(rst_n), .start_i(start_i),
    .cam_pclk_i(cam_pclk), .cam_href_i(cam_href), .cam_vsync_i(cam_vsync), .cam_data_i(cam_data),
    .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && we_o) begin
      wr_t e;
      n_wr++;
      last_adr = adr_o;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h expected no write", adr_o, dat_o);
      end else begin
        e = exp_q.pop_front();
        chk("write_adr_dat", 32'({adr_o, dat_o}), 32'(e));
      end
    end
  end

  function automatic bit keep(input int c, input int l);
    if (S == 2) return (c % 2 == 0) && (l % 2 == 0) && (c / 2 < H) && (l / 2 < V);
    return (c < H) && (l < V);
  endfunction

  task automatic put_byte(input logic [7:0] b);
    cam_data = b;
    #20 cam_pclk = 1;
    #20 cam_pclk = 0;
  endtask

  task automatic blank(input int n);
    repeat (n) put_byte(8'($urandom));
  endtask

  task automatic do_start();
    @(negedge clk);
    start_i = 1;
    if (!pending && !capturing) begin
      pending = 1;
      m_done = 0;
      m_err = 0;
    end
    @(negedge clk);
    start_i = 0;
  endtask

  task automatic cam_frame(input int nl, input int np, input int odd_line, input int empty_line,
                           input int mode, input bit fixed);
    int ml;
    logic [11:0] v;
    logic [3:0] hi;
    cam_vsync = 1;
    blank(3);
    cam_vsync = 0;
    if (pending) begin
      pending = 0;
      capturing = 1;
      m_addr = 0;
    end
    blank(4);
    ml = 0;
    for (int l = 0; l < nl; l++) begin
      if (l == empty_line) begin
        cam_href = 1;
        put_byte(8'($urandom));
        cam_href = 0;
        blank(3);
      end
      cam_href = 1;
      for (int c = 0; c < np; c++) begin
        v = 12'($urandom);
        hi = 4'($urandom);
        if (capturing && keep(c, ml)) begin
          if (mode == 1) v = 12'(m_addr % 4096);
          if (fixed && m_addr == 0) begin
            v = 12'hA5C;
            hi = 4'h0;
          end
          exp_q.push_back('{adr: AW'(m_addr), dat: v});
          m_addr++;
          if (m_addr == DEPTH) begin
            capturing = 0;
            m_done = 1;
          end
        end
        put_byte({hi, v[11:8]});
        put_byte(v[7:0]);
      end
      if (l == odd_line) put_byte(8'($urandom));
      cam_href = 0;
      blank(3);
      ml++;
    end
    cam_vsync = 1;
    if (capturing) begin
      capturing = 0;
      m_err = 1;
    end
    blank(2);
  endtask

  task automatic endchk(input string tag, input int exp_wr);
    repeat (20) @(negedge clk);
    chk({tag, "_done"}, 32'(done_o), 32'(m_done));
    chk({tag, "_err"}, 32'(err_o), 32'(m_err));
    chk({tag, "_busy"}, 32'(busy_o), 32'(pending || capturing));
    chk({tag, "_writes"}, 32'(n_wr - base), 32'(exp_wr));
    chk({tag, "_pending"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #3;
    #24;
    chk("rst_we", 32'(we_o), 0);
    chk("rst_adr", 32'(adr_o), 0);
    chk("rst_dat", 32'(dat_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    @(negedge clk);
    rst_n = 1;
    #3;

    do_start();
    chk("armed_busy", 32'(busy_o), 1);
    base = n_wr;
    cam_frame(V * S, H * S, -1, -1, 1, 0);
    endchk("full", DEPTH);
    chk("full_last_adr", 32'(last_adr), DEPTH - 1);

    do_start();
    base = n_wr;
    cam_frame(V * S + 1, H * S + 2, 2, 3, 0, 1);
    endchk("pairing", DEPTH);

    base = n_wr;
    fork
      cam_frame(V * S, H * S, -1, -1, 0, 0);
      begin
        repeat (300) @(negedge clk);
        do_start();
      end
    join
    endchk("midstart", 0);
    base = n_wr;
    cam_frame(V * S, H * S, -1, -1, 0, 0);
    endchk("after_midstart", DEPTH);

    do_start();
    base = n_wr;
    cam_frame(4 * S, H * S, -1, -1, 0, 0);
    endchk("short", 4 * H);

    do_start();
    base = n_wr;
    fork
      cam_frame(V * S, H * S, -1, -1, 0, 0);
      begin
        int k = 0;
        while (n_wr - base < 50 && k < 20000) begin
          @(negedge clk);
          k++;
        end
        if (n_wr - base < 50) chk("reset_trigger_timeout", 32'(n_wr - base), 50);
        #2 rst_n = 0;
        pending = 0;
        capturing = 0;
        m_done = 0;
        m_err = 0;
        exp_q.delete();
        rst_wr = n_wr;
        #1;
        chk("async_rst_we", 32'(we_o), 0);
        chk("async_rst_adr", 32'(adr_o), 0);
        chk("async_rst_dat", 32'(dat_o), 0);
        chk("async_rst_busy", 32'(busy_o), 0);
        chk("async_rst_done", 32'(done_o), 0);
        chk("async_rst_err", 32'(err_o), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
      end
    join
    repeat (20) @(negedge clk);
    chk("no_writes_after_reset", 32'(n_wr), 32'(rst_wr));
    chk("post_reset_busy", 32'(busy_o), 0);

    do_start();
    base = n_wr;
    cam_frame(V * S, H * S, -1, -1, 1, 0);
    endchk("rearm", DEPTH);
    chk("rearm_last_adr", 32'(last_adr), DEPTH - 1);

    do_start();
    base = n_wr;
    fork
      cam_frame(V * S, H * S, -1, -1, 0, 0);
      begin
        repeat (300) @(negedge clk);
        do_start();
      end
    join
    endchk("start_in_capture", DEPTH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cam_capture.md
# cam_capture

Front end of the camera path. Samples the OV7670 byte stream (pclk/href/vsync/data) in the system clock domain and packs byte pairs into 12-bit RGB444 pixels. Writes one armed frame into the frame-buffer RAM through a write-enable/address/data port. It directly feeds the image RAM's write side and reports frame completion to the Wishbone camera controller.

## Interface
- `H_OUT`, default 320: output pixels per line written to RAM.
- `V_OUT`, default 240: output lines per frame.
- `DEPTH`, default 76800: RAM words; must equal `H_OUT*V_OUT`.
- `ADR_W`, default 19: address width.
- `clk_i` in 1: system clock. Must run at ≥4× the camera pclk.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle pulse that arms capture of the next full frame.
- `cam_pclk_i` in 1: camera pixel clock, treated as asynchronous data.
- `cam_href_i` in 1: line valid, asynchronous.
- `cam_vsync_i` in 1: frame sync, active high, asynchronous.
- `cam_data_i` in 8: camera byte, asynchronous.
- `we_o` out 1: RAM write strobe, one cycle per pixel.
- `adr_o` out ADR_W: RAM write address.
- `dat_o` out 12: pixel {R[3:0],G[3:0],B[3:0]}.
- `busy_o` out 1: high in WAIT_VS and CAPTURE.
- `done_o` out 1: frame complete. Level; cleared by `start_i`.
- `err_o` out 1: short frame. Level; cleared by `start_i`.

## Operation
- Input sync: pclk, href, vsync and data each pass through 2 flops in `clk_i`. A pclk rising edge is detected from the 2nd/3rd flop stage. The synchronized href/vsync/data are sampled on that edge event ("pclk tick").
- Byte pairing: a phase bit toggles on each pclk tick with href=1 and is forced to 0 while href=0.
  - Phase 0: latch byte1[3:0] as R.
  - Phase 1: form pixel {byte1[3:0], byte2[7:0]}.
- FSM states:
  - IDLE: wait for `start_i`. On `start_i`, clear done/err, go to WAIT_VS.
  - WAIT_VS: wait for a synced vsync falling edge (end of the sync pulse = frame start). Then clear address, line and column counters and go to CAPTURE.
  - CAPTURE: each formed pixel that passes decimation produces one write. After the write at address DEPTH-1, set done_o and go to DONE. A vsync rising edge before that write sets err_o and goes to DONE.
  - DONE: outputs held. `start_i` re-arms (same action as in IDLE).
- `start_i` in WAIT_VS or CAPTURE is ignored.
- Counters:
  - Column counter increments per formed pixel and clears on the href falling edge.
  - Line counter increments on the href falling edge when at least one pixel was seen in that line.
- Address arithmetic: plain binary, +1 per write, no wrap. Pixels beyond DEPTH-1 are never written; the FSM has already left CAPTURE.
- Extra columns (col ≥ H_OUT after decimation) or lines (≥ V_OUT) are dropped silently.

## Timing
- Reset values: we_o=0, adr_o=0, dat_o=0, busy_o=0, done_o=0, err_o=0, FSM=IDLE, phase=0.
- Latency: second-byte pclk rising edge at the pin → `we_o` high 4 `clk_i` cycles later (2 sync + 1 edge detect + 1 output register).
- Write port:
  - `we_o` is high for exactly one cycle, with `adr_o` and `dat_o` valid in that same cycle.
  - `adr_o` advances in the cycle after the write.
  - The RAM is required to accept a write every cycle; there is no backpressure.
- `done_o` rises in the cycle after the final write.
- An async reset mid-frame aborts immediately. RAM contents are left undefined; the controller must re-arm.
- vsync edge and pixel write in the same tick: the write completes first, then the err check is applied.

## Configuration
- `CAM_CAPTURE_DECIM_EN`
  - Defined: 2×2 decimation. The sensor runs VGA 640×480; only even columns on even lines are written, giving H_OUT×V_OUT from 640×480.
  - Undefined: every formed pixel on every line is written. The sensor must be configured for QVGA 320×240.

## Structure
- Shared package `cam_pkg`: FSM state encoding (IDLE, WAIT_VS, CAPTURE, DONE), default H_OUT/V_OUT/DEPTH/ADR_W, and the RGB444 bit-slice constants.
- One sub-module, `cam_sync`: the 2-flop synchronizers plus pclk/href/vsync edge detectors, outputting one-cycle tick and edge pulses.

## Test plan
- Full frame, decimation off, 320×240 synthetic frame with pixel = address mod 4096 → 76800 writes; last write at adr 76799; done_o=1; err_o=0.
- Byte pairing: bytes 0x0A, 0x5C → dat_o=0xA5C; href dropped after an odd byte → phase resets and the next line's first pixel is correct.
- `start_i` mid-frame while vsync is low → no writes until after the next vsync falling edge.
- Short frame, vsync rising after 100 lines → 32000 writes; err_o=1; done_o=0.
- Reset asserted after 5000 writes → all outputs 0 asynchronously; a new `start_i` captures a clean frame from adr 0.
- Decimation on, 640×480 input with a column/row-coded pattern → only even/even pixels written; 76800 writes; done_o=1.
